// File: rtl/uart_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_ctrl_pkg : opcodes, response codes, register map and FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
package uart_ctrl_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;

  localparam logic [7:0] ADDR_CFG     = 8'd0;
  localparam logic [7:0] ADDR_SCRATCH = 8'd1;
  localparam logic [7:0] ADDR_ERR_CNT = 8'd2;
  localparam logic [7:0] ADDR_ID      = 8'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LATCH = 3'd2,
    EXEC  = 3'd3,
    RESP  = 3'd4,
    APPLY = 3'd5
  } state_t;

  // Number of bytes in a frame, decided by its first byte.
  function automatic logic [1:0] frame_len(input logic [7:0] op);
    if (op == OP_WRITE)     return 2'd3;
    else if (op == OP_READ) return 2'd2;
    else                    return 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_ctrl_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_ctrl_regfile : CFG / SCRATCH / ERR_CNT / ID registers
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_ctrl_regfile
  import uart_ctrl_pkg::*;
#(
  parameter logic [2:0] RESET_SEL    = 3'd3,
  parameter logic [1:0] RESET_PARITY = 2'b00,
  parameter logic [7:0] DEV_ID       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scratch_we,
  input  logic [7:0] scratch_din,
  input  logic       cfg_we,
  input  logic [4:0] cfg_din,
  input  logic       err_inc,
  input  logic       err_clr,
  input  logic [1:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [2:0] baud_sel,
  output logic [1:0] parity_mode,
  output logic [7:0] err_cnt
);

  logic [7:0] scratch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_sel    <= RESET_SEL;
      parity_mode <= RESET_PARITY;
      scratch     <= 8'h00;
      err_cnt     <= 8'h00;
    end else begin
      if (cfg_we) begin
        baud_sel    <= cfg_din[2:0];
        parity_mode <= cfg_din[4:3];
      end
      if (scratch_we) scratch <= scratch_din;
      // Clear wins over a coincident error; the count saturates at 0xFF.
      if (err_clr)                        err_cnt <= 8'h00;
      else if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      2'd0:    rd_data = {3'b000, parity_mode, baud_sel};
      2'd1:    rd_data = scratch;
      2'd2:    rd_data = err_cnt;
      default: rd_data = DEV_ID;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_cmd_ctrl : byte-frame command parser between rx/tx FIFOs and regfile
// Rev 1.0
// ---------------------------------------------------------------------------
module uart_cmd_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter logic [2:0] RESET_SEL      = 3'd3,
  parameter logic [1:0] RESET_PARITY   = 2'b00,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] DEV_ID         = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_fifo_empty,
  input  logic [7:0] rx_fifo_dout,
  output logic       rx_fifo_rd_en,
  input  logic       tx_fifo_full,
  output logic       tx_fifo_wr_en,
  output logic [7:0] tx_fifo_din,
  input  logic       tx_idle,
  output logic [2:0] baud_sel,
  output logic [1:0] parity_mode,
  output logic [7:0] err_cnt
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [1:0]       byte_idx;
  logic [GAP_W-1:0] gap;
  logic [7:0]       op_q, addr_q, data_q;
  logic [7:0]       resp_q;
  logic [4:0]       cfg_pending;
  logic             apply_pending;

  logic       is_wr, is_rd, bad, exec, timeout_hit, cfg_ok;
  logic [7:0] rd_data, resp_val, cur_op;

  always_comb begin
    is_wr  = (op_q == OP_WRITE);
    is_rd  = (op_q == OP_READ);
    bad    = !(is_wr || is_rd) || (addr_q > ADDR_ID)
           || (is_wr && addr_q == ADDR_ID)
           || (is_wr && addr_q == ADDR_CFG && data_q[4:3] == 2'b11);
    exec   = (state == EXEC);
    cfg_ok = is_wr && !bad && (addr_q == ADDR_CFG);
    resp_val = bad ? RESP_NAK : (is_wr ? RESP_ACK : rd_data);
    timeout_hit = (state == IDLE) && (byte_idx != 2'd0) && rx_fifo_empty
                && (gap == GAP_LAST);
    cur_op = (byte_idx == 2'd0) ? rx_fifo_dout : op_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      byte_idx      <= 2'd0;
      gap           <= '0;
      op_q          <= 8'h00;
      addr_q        <= 8'h00;
      data_q        <= 8'h00;
      resp_q        <= 8'h00;
      cfg_pending   <= 5'd0;
      apply_pending <= 1'b0;
      rx_fifo_rd_en <= 1'b0;
      tx_fifo_wr_en <= 1'b0;
      tx_fifo_din   <= 8'h00;
    end else begin
      rx_fifo_rd_en <= 1'b0;
      tx_fifo_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_fifo_empty) begin
            state         <= POP;
            rx_fifo_rd_en <= 1'b1;
            gap           <= '0;
          end else if (byte_idx != 2'd0) begin
            if (timeout_hit) begin
              byte_idx <= 2'd0;
              gap      <= '0;
            end else begin
              gap <= gap + 1'b1;
            end
          end
        end
        POP: state <= LATCH;
        LATCH: begin
          case (byte_idx)
            2'd0:    op_q   <= rx_fifo_dout;
            2'd1:    addr_q <= rx_fifo_dout;
            default: data_q <= rx_fifo_dout;
          endcase
          if (byte_idx + 2'd1 == frame_len(cur_op)) begin
            state <= EXEC;
          end else begin
            byte_idx <= byte_idx + 2'd1;
            state    <= IDLE;
          end
        end
        EXEC: begin
          resp_q        <= resp_val;
          cfg_pending   <= data_q[4:0];
          apply_pending <= cfg_ok;
          state         <= RESP;
        end
        RESP: begin
          if (!tx_fifo_full) begin
            tx_fifo_wr_en <= 1'b1;
            tx_fifo_din   <= resp_q;
            byte_idx      <= 2'd0;
            state         <= apply_pending ? APPLY : IDLE;
          end
        end
        APPLY: begin
          // New line settings wait until the ACK has fully left at the old rate.
          if (tx_idle) begin
            apply_pending <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_ctrl_regfile #(
    .RESET_SEL    (RESET_SEL),
    .RESET_PARITY (RESET_PARITY),
    .DEV_ID       (DEV_ID)
  ) u_regfile (
    .clk         (clk),
    .rst_n       (rst_n),
    .scratch_we  (exec && is_wr && !bad && addr_q == ADDR_SCRATCH),
    .scratch_din (data_q),
    .cfg_we      (state == APPLY && tx_idle),
    .cfg_din     (cfg_pending),
    .err_inc     ((exec && bad) || timeout_hit),
    .err_clr     (exec && is_wr && !bad && addr_q == ADDR_ERR_CNT),
    .rd_addr     (addr_q[1:0]),
    .rd_data     (rd_data),
    .baud_sel    (baud_sel),
    .parity_mode (parity_mode),
    .err_cnt     (err_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_cmd_ctrl : self-checking bench with FIFO models and register model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_fifo_empty = 1'b1;
  logic [7:0] rx_fifo_dout = 8'h00;
  logic       rx_fifo_rd_en;
  logic       tx_fifo_full = 1'b0;
  logic       tx_fifo_wr_en;
  logic [7:0] tx_fifo_din;
  logic       tx_idle = 1'b1;
  logic [2:0] baud_sel;
  logic [1:0] parity_mode;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_got[$];
  bit         both_hi = 1'b0;

  // behavioural register model
  logic [2:0] m_baud;
  logic [1:0] m_par;
  logic [7:0] m_scratch;
  logic [7:0] m_err;

  uart_cmd_ctrl #(
    .RESET_SEL      (3'd3),
    .RESET_PARITY   (2'b00),
    .TIMEOUT_CYCLES (16),
    .DEV_ID         (8'hA5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_fifo_empty (rx_fifo_empty),
    .rx_fifo_dout  (rx_fifo_dout),
    .rx_fifo_rd_en (rx_fifo_rd_en),
    .tx_fifo_full  (tx_fifo_full),
    .tx_fifo_wr_en (tx_fifo_wr_en),
    .tx_fifo_din   (tx_fifo_din),
    .tx_idle       (tx_idle),
    .baud_sel      (baud_sel),
    .parity_mode   (parity_mode),
    .err_cnt       (err_cnt)
  );

  always #5 clk = ~clk;

  // rx FIFO model: data appears the cycle after rd_en
  always @(posedge clk) begin
    logic [7:0] b;
    if (rx_fifo_rd_en && rx_q.size() > 0) begin
      b = rx_q.pop_front();
      rx_fifo_dout <= b;
    end
    rx_fifo_empty <= (rx_q.size() == 0);
  end

  // tx FIFO capture
  always @(posedge clk) begin
    if (tx_fifo_wr_en) tx_got.push_back(tx_fifo_din);
    if (tx_fifo_wr_en && rx_fifo_rd_en) both_hi <= 1'b1;
  end

  function automatic int flen(input logic [7:0] op);
    if (op == 8'h57) return 3;
    if (op == 8'h52) return 2;
    return 1;
  endfunction

  task automatic model_reset();
    m_baud = 3'd3; m_par = 2'b00; m_scratch = 8'h00; m_err = 8'h00;
  endtask

  // Returns the expected response and updates the model registers.
  function automatic logic [7:0] model_frame(input logic [7:0] op, addr, data);
    logic [7:0] r;
    r = 8'h15;
    if (op == 8'h52) begin
      if (addr == 8'd0)      r = {3'b000, m_par, m_baud};
      else if (addr == 8'd1) r = m_scratch;
      else if (addr == 8'd2) r = m_err;
      else if (addr == 8'd3) r = 8'hA5;
    end else if (op == 8'h57) begin
      if (addr == 8'd0 && data[4:3] != 2'b11) begin
        m_baud = data[2:0]; m_par = data[4:3]; r = 8'h06;
      end else if (addr == 8'd1) begin
        m_scratch = data; r = 8'h06;
      end else if (addr == 8'd2) begin
        m_err = 8'h00; r = 8'h06;
      end
    end
    if (r == 8'h15 && m_err != 8'hFF) m_err = m_err + 8'd1;
    return r;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    rx_q.push_back(b);
  endtask

  task automatic wait_tx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tx_got.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rx_q.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Send one frame, compare its response and the visible registers with the model.
  task automatic run_frame(input logic [7:0] op, addr, data, input string nm);
    logic [7:0] exp;
    int n0, len;
    bit ok;
    len = flen(op);
    exp = model_frame(op, addr, data);
    n0  = tx_got.size();
    push_byte(op);
    if (len > 1) push_byte(addr);
    if (len > 2) push_byte(data);
    wait_tx(n0 + 1, 200, ok);
    n_checks++;
    if (!ok) $display("FAIL %s resp: no tx write seen, required %02h", nm, exp);
    else if (tx_got[n0] !== exp) $display("FAIL %s resp: got %02h required %02h", nm, tx_got[n0], exp);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({baud_sel, parity_mode, err_cnt} !== {m_baud, m_par, m_err})
      $display("FAIL %s regs: baud/par/err got %0d/%0d/%02h required %0d/%0d/%02h",
               nm, baud_sel, parity_mode, err_cnt, m_baud, m_par, m_err);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({rx_fifo_rd_en, tx_fifo_wr_en, tx_fifo_din} !== {1'b0, 1'b0, 8'h00})
      $display("FAIL reset_fifo_if: rd/wr/din got %b/%b/%02h required 0/0/00",
               rx_fifo_rd_en, tx_fifo_wr_en, tx_fifo_din);
    else n_pass++;
    n_checks++;
    if ({baud_sel, parity_mode, err_cnt} !== {3'd3, 2'b00, 8'h00})
      $display("FAIL reset_regs: baud/par/err got %0d/%0d/%02h required 3/0/00",
               baud_sel, parity_mode, err_cnt);
    else n_pass++;
  endtask

  task automatic test_scratch();
    run_frame(8'h57, 8'h01, 8'h3C, "scratch_wr");
    run_frame(8'h52, 8'h01, 8'h00, "scratch_rd");
    n_checks++;
    if (m_scratch !== 8'h3C || tx_got[tx_got.size()-1] !== 8'h3C)
      $display("FAIL scratch_val: got %02h required 3c", tx_got[tx_got.size()-1]);
    else n_pass++;
  endtask

  task automatic test_cfg_apply();
    logic [7:0] exp;
    int n0;
    bit ok, held;
    tx_idle = 1'b0;
    exp = model_frame(8'h57, 8'h00, 8'h0A);
    n0  = tx_got.size();
    push_byte(8'h57); push_byte(8'h00); push_byte(8'h0A);
    wait_tx(n0 + 1, 200, ok);
    n_checks++;
    if (!ok || tx_got[n0] !== exp)
      $display("FAIL cfg_ack: ok=%0d got %02h required %02h", ok, ok ? tx_got[n0] : 8'h00, exp);
    else n_pass++;
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (baud_sel !== 3'd3 || parity_mode !== 2'b00) held = 1'b0;
    end
    n_checks++;
    if (!held) $display("FAIL cfg_hold: baud changed to %0d before tx_idle, required 3", baud_sel);
    else n_pass++;
    tx_idle = 1'b1;
    @(negedge clk);
    n_checks++;
    if (baud_sel !== 3'd2 || parity_mode !== 2'b01)
      $display("FAIL cfg_apply: baud/par got %0d/%0d required 2/1", baud_sel, parity_mode);
    else n_pass++;
  endtask

  task automatic test_errors();
    run_frame(8'h41, 8'h00, 8'h00, "bad_op");
    run_frame(8'h57, 8'h03, 8'hFF, "wr_id");
    run_frame(8'h57, 8'h00, 8'h18, "cfg_par11");
    n_checks++;
    if (err_cnt !== 8'd3) $display("FAIL err_three: got %02h required 03", err_cnt);
    else n_pass++;
    run_frame(8'h52, 8'h03, 8'h00, "rd_id");
    run_frame(8'h52, 8'h00, 8'h00, "rd_cfg");
    run_frame(8'h57, 8'h07, 8'h00, "bad_addr");
    run_frame(8'h57, 8'h02, 8'h00, "err_clr");
    n_checks++;
    if (err_cnt !== 8'd0) $display("FAIL err_cleared: got %02h required 00", err_cnt);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int n0;
    n0 = tx_got.size();
    push_byte(8'h57); push_byte(8'h01);
    repeat (40) @(negedge clk);
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
    n_checks++;
    if (tx_got.size() != n0 || err_cnt !== m_err)
      $display("FAIL timeout: tx writes %0d err %02h required 0 writes err %02h",
               tx_got.size() - n0, err_cnt, m_err);
    else n_pass++;
    run_frame(8'h52, 8'h01, 8'h00, "timeout_rd");
  endtask

  task automatic test_backpressure();
    logic [7:0] exp;
    int n0, act;
    bit ok;
    tx_fifo_full = 1'b1;
    exp = model_frame(8'h52, 8'h03, 8'h00);
    n0  = tx_got.size();
    push_byte(8'h52); push_byte(8'h03);
    repeat (12) @(negedge clk);
    act = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_fifo_wr_en || rx_fifo_rd_en) act++;
    end
    n_checks++;
    if (act != 0 || tx_got.size() != n0)
      $display("FAIL bp_hold: strobes %0d writes %0d required 0/0", act, tx_got.size() - n0);
    else n_pass++;
    tx_fifo_full = 1'b0;
    wait_tx(n0 + 1, 20, ok);
    repeat (10) @(negedge clk);
    n_checks++;
    if (!ok || tx_got.size() != n0 + 1 || tx_got[n0] !== exp)
      $display("FAIL bp_release: writes %0d required 1, value %02h required %02h",
               tx_got.size() - n0, ok ? tx_got[n0] : 8'h00, exp);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] op, addr, data;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    op = 8'h57;
        2:       op = 8'h52;
        default: op = 8'($urandom);
      endcase
      addr = 8'($urandom_range(0, 5));
      data = 8'($urandom);
      run_frame(op, addr, data, "random");
    end
  endtask

  task automatic test_saturate();
    int n0;
    bit ok, all_nak;
    logic [7:0] e;
    n0 = tx_got.size();
    for (int i = 0; i < 260; i++) begin
      e = model_frame(8'($urandom_range(8'h60, 8'hFF)), 8'h00, 8'h00);
      push_byte(8'h60 + 8'(i % 100));
    end
    wait_tx(n0 + 260, 4000, ok);
    repeat (5) @(negedge clk);
    all_nak = ok;
    for (int i = 0; ok && i < 260; i++) if (tx_got[n0 + i] !== 8'h15) all_nak = 1'b0;
    n_checks++;
    if (!all_nak) $display("FAIL sat_naks: complete=%0d, required 260 NAK bytes", ok);
    else n_pass++;
    n_checks++;
    if (err_cnt !== 8'hFF || m_err !== 8'hFF) $display("FAIL sat_err: got %02h required ff", err_cnt);
    else n_pass++;
    run_frame(8'h57, 8'h02, 8'h55, "sat_clr");
  endtask

  task automatic test_reset_midframe();
    int n0;
    run_frame(8'h57, 8'h01, 8'h99, "pre_rst");
    push_byte(8'h57); push_byte(8'h01);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rx_fifo_rd_en, tx_fifo_wr_en, tx_fifo_din, baud_sel, parity_mode, err_cnt}
        !== {1'b0, 1'b0, 8'h00, 3'd3, 2'b00, 8'h00})
      $display("FAIL rst_async: rd/wr/din/baud/par/err got %b/%b/%02h/%0d/%0d/%02h required 0/0/00/3/0/00",
               rx_fifo_rd_en, tx_fifo_wr_en, tx_fifo_din, baud_sel, parity_mode, err_cnt);
    else n_pass++;
    model_reset();
    rx_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n0 = tx_got.size();
    repeat (30) @(negedge clk);
    n_checks++;
    if (tx_got.size() != n0 || err_cnt !== 8'h00)
      $display("FAIL rst_discard: writes %0d err %02h required 0/00", tx_got.size() - n0, err_cnt);
    else n_pass++;
    run_frame(8'h52, 8'h01, 8'h00, "rst_scratch");
    // reset while a config change is waiting for tx_idle
    tx_idle = 1'b0;
    n0 = tx_got.size();
    push_byte(8'h57); push_byte(8'h00); push_byte(8'h0C);
    repeat (20) @(negedge clk);
    do_reset();
    tx_idle = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (baud_sel !== 3'd3 || parity_mode !== 2'b00 || tx_got.size() != n0 + 1)
      $display("FAIL rst_apply: baud/par %0d/%0d writes %0d required 3/0/1",
               baud_sel, parity_mode, tx_got.size() - n0);
    else n_pass++;
  endtask

  task automatic test_exclusive();
    n_checks++;
    if (both_hi !== 1'b0) $display("FAIL strobe_overlap: rd_en and wr_en seen together");
    else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scratch();
    test_cfg_apply();
    test_errors();
    test_timeout();
    test_backpressure();
    test_random();
    test_saturate();
    test_reset_midframe();
    test_exclusive();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
